// File: rtl/frame_color_classifier_if.sv
// Frame colour classifier bus: pixel stream in, per-frame verdict out.
// master: EN, PIXEL_X/Y/IN out; slave: RESULT, RESULT_VALID, RED/BLUE_COUNT out.
interface frame_color_classifier_if #(
  parameter int CNT_W = 15
);
  logic             EN;
  logic [9:0]       PIXEL_X;
  logic [9:0]       PIXEL_Y;
  logic [7:0]       PIXEL_IN;
  logic [1:0]       RESULT;
  logic             RESULT_VALID;
  logic [CNT_W-1:0] RED_COUNT;
  logic [CNT_W-1:0] BLUE_COUNT;

  modport master (
    output EN, PIXEL_X, PIXEL_Y, PIXEL_IN,
    input  RESULT, RESULT_VALID, RED_COUNT, BLUE_COUNT
  );

  modport slave (
    input  EN, PIXEL_X, PIXEL_Y, PIXEL_IN,
    output RESULT, RESULT_VALID, RED_COUNT, BLUE_COUNT
  );
endinterface

// File: rtl/frame_color_classifier.sv
// Counts red/blue-dominant RGB332 pixels per frame and publishes a verdict.
// Ports: CLOCK, RESET_N (async, low), bus (slave: EN, PIXEL_X/Y/IN in;
// RESULT, RESULT_VALID, RED_COUNT, BLUE_COUNT out).
// Option FRAME_COLOR_HYST_EN: publish only when the raw verdict repeats.
module frame_color_classifier #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 120,
  parameter int MIN_COUNT     = 500,
  parameter int CNT_W         = 15
) (
  input  logic CLOCK,
  input  logic RESET_N,
  frame_color_classifier_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_SOF,
    ACCUM,
    DECIDE
  } state_t;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_RED  = 2'b01;
  localparam logic [1:0] RES_BLUE = 2'b10;

  localparam logic [9:0] X_LAST = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(SCREEN_HEIGHT - 1);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_COUNT);

  state_t state_q, state_d;

  logic [9:0] x_d, y_d;
  logic       v_d;

  logic [CNT_W-1:0] red_q, red_d;
  logic [CNT_W-1:0] blue_q, blue_d;

  logic [1:0]       result_q;
  logic             valid_q;
  logic [CNT_W-1:0] red_out_q;
  logic [CNT_W-1:0] blue_out_q;

  logic       in_win, sof, eof;
  logic       is_red, is_blue;
  logic       decide;
  logic [1:0] raw;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] c,
    input logic             inc
  );
    return (inc && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // v_d keeps the reset value 0,0 of x_d/y_d from posing as a sof.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_d <= '0;
      y_d <= '0;
      v_d <= 1'b0;
    end else begin
      x_d <= bus.PIXEL_X;
      y_d <= bus.PIXEL_Y;
      v_d <= 1'b1;
    end
  end

  assign in_win = v_d && (x_d <= X_LAST) && (y_d <= Y_LAST);
  assign sof = in_win && (x_d == '0) && (y_d == '0);
  assign eof = in_win && (x_d == X_LAST) && (y_d == Y_LAST);

  assign is_red = (bus.PIXEL_IN[7:5] >= 3'd5)
               && (bus.PIXEL_IN[4:2] <= 3'd2)
               && (bus.PIXEL_IN[1:0] <= 2'd1);

  assign is_blue = (bus.PIXEL_IN[1:0] == 2'd3)
                && (bus.PIXEL_IN[7:5] <= 3'd2)
                && (bus.PIXEL_IN[4:2] <= 3'd2);

  always_comb begin
    raw = RES_NONE;
    if (red_q > blue_q && red_q >= MIN_C)
      raw = RES_RED;
    else if (blue_q > red_q && blue_q >= MIN_C)
      raw = RES_BLUE;
  end

  assign decide = (state_q == DECIDE) && bus.EN;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= WAIT_SOF;
      red_q   <= '0;
      blue_q  <= '0;
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
      blue_q  <= blue_d;
    end
  end

  // eof wins over sof so a 1x1 window still reaches DECIDE.
  always_comb begin
    state_d = state_q;
    red_d   = red_q;
    blue_d  = blue_q;
    if (!bus.EN) begin
      state_d = WAIT_SOF;
    end else begin
      unique case (state_q)
        WAIT_SOF: begin
          if (sof) begin
            red_d   = CNT_W'(is_red);
            blue_d  = CNT_W'(is_blue);
            state_d = eof ? DECIDE : ACCUM;
          end
        end
        ACCUM: begin
          if (eof) begin
            red_d   = sat_inc(red_q, is_red);
            blue_d  = sat_inc(blue_q, is_blue);
            state_d = DECIDE;
          end else if (sof) begin
            red_d  = CNT_W'(is_red);
            blue_d = CNT_W'(is_blue);
          end else if (in_win) begin
            red_d  = sat_inc(red_q, is_red);
            blue_d = sat_inc(blue_q, is_blue);
          end
        end
        DECIDE: begin
          state_d = WAIT_SOF;
        end
        default: begin
          state_d = WAIT_SOF;
        end
      endcase
    end
  end

`ifdef FRAME_COLOR_HYST_EN
  logic [1:0] prev_q;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      result_q   <= RES_NONE;
      valid_q    <= 1'b0;
      red_out_q  <= '0;
      blue_out_q <= '0;
`ifdef FRAME_COLOR_HYST_EN
      prev_q     <= RES_NONE;
`endif
    end else begin
      valid_q <= 1'b0;
      if (decide) begin
        red_out_q  <= red_q;
        blue_out_q <= blue_q;
`ifdef FRAME_COLOR_HYST_EN
        prev_q <= raw;
        if (raw == prev_q) begin
          result_q <= raw;
          valid_q  <= 1'b1;
        end
`else
        result_q <= raw;
        valid_q  <= 1'b1;
`endif
      end
    end
  end

  assign bus.RESULT       = result_q;
  assign bus.RESULT_VALID = valid_q;
  assign bus.RED_COUNT    = red_out_q;
  assign bus.BLUE_COUNT   = blue_out_q;

endmodule

// File: tb/tb_frame_color_classifier.sv
// Directed bench for frame_color_classifier: frame-level model plus
// per-cycle compare of RESULT, RESULT_VALID, RED_COUNT, BLUE_COUNT.
module tb_frame_color_classifier;

  localparam int W = 176;
  localparam int H = 120;
  localparam int MINC = 500;
`ifdef FRAME_COLOR_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  typedef struct {
    int         cyc;
    logic [1:0] res;
    int         r;
    int         b;
    bit         pulse;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;

  frame_color_classifier_if #(.CNT_W(15)) bus ();

  frame_color_classifier dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #20 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t        evq[$];
  logic [1:0] exp_res = 2'b00;
  bit         exp_valid = 1'b0;
  int         exp_red = 0;
  int         exp_blue = 0;

  bit         m_act = 1'b0;
  int         mr = 0;
  int         mb = 0;
  logic [1:0] m_prev = 2'b00;
  bit         en_v = 1'b1;
  logic [7:0] prev_d = 8'h00;

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t ev;
    exp_valid = 1'b0;
    if (evq.size() != 0 && evq[0].cyc == cyc) begin
      ev = evq.pop_front();
      if (ev.pulse) begin
        exp_res   = ev.res;
        exp_valid = 1'b1;
      end
      exp_red  = ev.r;
      exp_blue = ev.b;
    end
    chk("RESULT", int'(bus.RESULT), int'(exp_res));
    chk("RESULT_VALID", int'(bus.RESULT_VALID), int'(exp_valid));
    chk("RED_COUNT", int'(bus.RED_COUNT), exp_red);
    chk("BLUE_COUNT", int'(bus.BLUE_COUNT), exp_blue);
  end

  function automatic bit px_red(input logic [7:0] d);
    return d[7:5] >= 5 && d[4:2] <= 2 && d[1:0] <= 1;
  endfunction

  function automatic bit px_blue(input logic [7:0] d);
    return d[1:0] == 3 && d[7:5] <= 2 && d[4:2] <= 2;
  endfunction

  // Frame-level model: a frame runs from a sof to an eof with EN high
  // throughout; its verdict shows two edges after the eof is sampled.
  task automatic model_pix(input int x, input int y, input logic [7:0] d);
    ev_t        ev;
    logic [1:0] raw;
    if (!en_v) begin
      m_act = 1'b0;
    end else if (x < W && y < H) begin
      if (x == 0 && y == 0) begin
        m_act = 1'b1;
        mr = 0;
        mb = 0;
      end
      if (m_act) begin
        mr += int'(px_red(d));
        mb += int'(px_blue(d));
        if (x == W - 1 && y == H - 1) begin
          raw = 2'b00;
          if (mr > mb && mr >= MINC) raw = 2'b01;
          if (mb > mr && mb >= MINC) raw = 2'b10;
          ev.cyc = cyc + 3;
          ev.res = raw;
          ev.r = mr;
          ev.b = mb;
          ev.pulse = HYST ? (raw == m_prev) : 1'b1;
          m_prev = raw;
          evq.push_back(ev);
          m_act = 1'b0;
        end
      end
    end
  endtask

  // RAM behaviour: data for a coordinate appears one cycle after it.
  task automatic drive(input int x, input int y, input logic [7:0] d);
    @(negedge clk);
    bus.EN = en_v;
    bus.PIXEL_X = 10'(x);
    bus.PIXEL_Y = 10'(y);
    bus.PIXEL_IN = prev_d;
    prev_d = d;
    model_pix(x, y, d);
  endtask

  task automatic seg(input int x0, input int y0, input int n,
                     input logic [7:0] d);
    int x = x0;
    int y = y0;
    for (int i = 0; i < n; i++) begin
      drive(x, y, d);
      x++;
      if (x == W) begin
        x = 0;
        y++;
      end
    end
  endtask

  task automatic idle_until(input int t);
    while (cyc < t) drive(200, 200, 8'h00);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    evq.delete();
    exp_res = 2'b00;
    exp_red = 0;
    exp_blue = 0;
    m_act = 1'b0;
    m_prev = 2'b00;
    repeat (3) drive(200, 200, 8'h00);
    @(posedge clk);
    #5;
    rst_n = 1'b1;
  endtask

  // Called right after the eof coordinate is driven.
  task automatic finish_frame(input logic [1:0] er, input int r,
                              input int b, input bit pulse);
    int c = cyc;
    idle_until(c + 2);
    chk("pin_pre_valid", int'(bus.RESULT_VALID), 0);
    idle_until(c + 3);
    chk("pin_valid", int'(bus.RESULT_VALID), int'(pulse));
    chk("pin_result", int'(bus.RESULT), int'(er));
    chk("pin_red", int'(bus.RED_COUNT), r);
    chk("pin_blue", int'(bus.BLUE_COUNT), b);
    idle_until(c + 4);
    chk("pin_post_valid", int'(bus.RESULT_VALID), 0);
    idle_until(c + 6);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.EN = 1'b1;
    bus.PIXEL_X = 10'd200;
    bus.PIXEL_Y = 10'd200;
    bus.PIXEL_IN = 8'h00;
    repeat (3) @(posedge clk);
    #5;
    rst_n = 1'b1;
    idle_until(cyc + 4);
    chk("reset_result", int'(bus.RESULT), 0);
    chk("reset_red", int'(bus.RED_COUNT), 0);

    // Reset at row 60: the rest of that frame gives no verdict.
    seg(0, 0, 100, 8'hE0);
    seg(0, 60, 40, 8'hE0);
    do_reset();
    seg(40, 60, 20, 8'hE0);
    drive(W - 1, H - 1, 8'hE0);
    idle_until(cyc + 6);

    // Full red frame.
    seg(0, 0, W * H, 8'hE0);
    finish_frame(HYST ? 2'b00 : 2'b01, W * H, 0, !HYST);

    // Full blue frame.
    seg(0, 0, W * H, 8'h03);
    finish_frame(HYST ? 2'b00 : 2'b10, 0, W * H, !HYST);

    // 300 blue, rest 0xFF: below MIN_COUNT.
    seg(0, 0, 300, 8'h03);
    seg(124, 1, 20, 8'hFF);
    drive(W - 1, H - 1, 8'hFF);
    finish_frame(2'b00, 0, 300, !HYST);

    // Tie 1000/1000 plus out-of-window red pixels.
    seg(0, 0, 1000, 8'hE0);
    seg(120, 5, 1000, 8'h03);
    drive(176, 7, 8'hE0);
    drive(10, 120, 8'hE0);
    drive(176, 120, 8'hE0);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(2'b00, 1000, 1000, 1'b1);

    // sof re-issued at row 80 restarts the count.
    seg(0, 0, 200, 8'hE0);
    seg(0, 80, 10, 8'hE0);
    seg(0, 0, 600, 8'h03);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(HYST ? 2'b00 : 2'b10, 0, 600, !HYST);

    // EN low for 5 cycles mid-frame discards it.
    seg(0, 0, 700, 8'hE0);
    en_v = 1'b0;
    seg(172, 3, 5, 8'hE0);
    en_v = 1'b1;
    seg(1, 4, 10, 8'hE0);
    drive(W - 1, H - 1, 8'hE0);
    idle_until(cyc + 8);
    seg(0, 0, 800, 8'hE0);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(HYST ? 2'b00 : 2'b01, 800, 0, !HYST);

    // RED, BLUE, BLUE, BLUE from a clean reset.
    do_reset();
    idle_until(cyc + 2);
    seg(0, 0, 600, 8'hE0);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(HYST ? 2'b00 : 2'b01, 600, 0, !HYST);
    seg(0, 0, 600, 8'h03);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(HYST ? 2'b00 : 2'b10, 0, 600, !HYST);
    seg(0, 0, 700, 8'h03);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(2'b10, 0, 700, 1'b1);
    seg(0, 0, 800, 8'h03);
    drive(W - 1, H - 1, 8'h00);
    finish_frame(2'b10, 0, 800, 1'b1);

    idle_until(cyc + 4);
    chk("queue_drained", evq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
